// File: rtl/checkpoint_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: latches a checkpoint, snapshots its RAT maps
// and GHR, replays the maps chunk by chunk into the RAT and rewrites the predictor GHR.
module checkpoint_recovery_ctrl #(
   parameter int CHECKPOINT_ID_WIDTH = 4,
   parameter int PHY_REG_NUM         = 64,
   parameter int RESTORE_CHUNK       = 16,
   parameter int GHR_WIDTH           = 16,
   localparam int N                  = PHY_REG_NUM / RESTORE_CHUNK,
   localparam int IDX_W              = (N > 1) ? $clog2(N) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           exbru_recov_req,
   input  logic [CHECKPOINT_ID_WIDTH-1:0] exbru_recov_id,
   input  logic                           exbru_recov_taken,
   output logic                           recov_exbru_ready,
   input  logic                           commit_recov_flush,
   output logic [CHECKPOINT_ID_WIDTH-1:0] recov_cpbuf_id,
   input  logic [PHY_REG_NUM-1:0]         cpbuf_recov_valid_map,
   input  logic [PHY_REG_NUM-1:0]         cpbuf_recov_visible_map,
   input  logic [GHR_WIDTH-1:0]           cpbuf_recov_ghr,
   output logic                           recov_rat_we,
   output logic [IDX_W-1:0]               recov_rat_idx,
   output logic [RESTORE_CHUNK-1:0]       recov_rat_valid_chunk,
   output logic [RESTORE_CHUNK-1:0]       recov_rat_visible_chunk,
   output logic                           recov_bp_ghr_we,
   output logic [GHR_WIDTH-1:0]           recov_bp_ghr,
   output logic                           recov_busy,
   output logic                           recov_done
);

   typedef enum logic [1:0] {IDLE, LATCH, RESTORE, DONE} state_t;

   state_t                         state_reg, state_next;
   logic [IDX_W-1:0]               count_reg, count_next;
   logic [CHECKPOINT_ID_WIDTH-1:0] id_reg;
   logic                           taken_reg;
   logic [PHY_REG_NUM-1:0]         snap_valid_reg, snap_visible_reg;
   logic [GHR_WIDTH-1:0]           snap_ghr_reg, bp_ghr_reg;
   logic [GHR_WIDTH-1:0]           ghr_fix;
   logic                           last_chunk;
   logic                           first_chunk;
   logic                           accept;

   logic [RESTORE_CHUNK-1:0] valid_chunks   [N];
   logic [RESTORE_CHUNK-1:0] visible_chunks [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_chunk
      assign valid_chunks[gi]   = snap_valid_reg[gi*RESTORE_CHUNK +: RESTORE_CHUNK];
      assign visible_chunks[gi] = snap_visible_reg[gi*RESTORE_CHUNK +: RESTORE_CHUNK];
   end

   assign last_chunk  = (count_reg == IDX_W'(N-1));
   assign first_chunk = (count_reg == '0);
   assign ghr_fix     = {snap_ghr_reg[GHR_WIDTH-2:0], taken_reg};
   assign accept      = exbru_recov_req && recov_exbru_ready;

   always_comb begin
      state_next              = state_reg;
      count_next              = count_reg;
      recov_exbru_ready       = (state_reg == IDLE) && !commit_recov_flush;
      recov_busy              = (state_reg != IDLE);
      recov_cpbuf_id          = id_reg;
      recov_rat_we            = 1'b0;
      recov_rat_idx           = count_reg;
      recov_rat_valid_chunk   = valid_chunks[count_reg];
      recov_rat_visible_chunk = visible_chunks[count_reg];
      recov_bp_ghr_we         = 1'b0;
      recov_bp_ghr            = bp_ghr_reg;
      recov_done              = 1'b0;

      if (state_reg == RESTORE && first_chunk)
         recov_bp_ghr = ghr_fix;

      // A flush wins over everything, including strobes already decoded for this cycle.
      if (commit_recov_flush) begin
         state_next = IDLE;
         count_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (exbru_recov_req)
                  state_next = LATCH;
            end
            LATCH: begin
               state_next = RESTORE;
               count_next = '0;
            end
            RESTORE: begin
               recov_rat_we    = 1'b1;
               recov_bp_ghr_we = first_chunk;
               if (last_chunk) begin
                  state_next = DONE;
                  count_next = '0;
               end else begin
                  count_next = count_reg + 1'b1;
               end
            end
            DONE: begin
               recov_done = 1'b1;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= IDLE;
         count_reg        <= '0;
         id_reg           <= '0;
         taken_reg        <= 1'b0;
         snap_valid_reg   <= '0;
         snap_visible_reg <= '0;
         snap_ghr_reg     <= '0;
         bp_ghr_reg       <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         if (accept) begin
            id_reg    <= exbru_recov_id;
            taken_reg <= exbru_recov_taken;
         end
         // Snapshot isolates the replay from rename writes landing after LATCH.
         if (state_reg == LATCH && !commit_recov_flush) begin
            snap_valid_reg   <= cpbuf_recov_valid_map;
            snap_visible_reg <= cpbuf_recov_visible_map;
            snap_ghr_reg     <= cpbuf_recov_ghr;
         end
         if (recov_bp_ghr_we)
            bp_ghr_reg <= ghr_fix;
      end
   end

endmodule
